ham_dec: RTL and testbench
==========================

HAM_DEC -- requirements
Module: ham_dec

Interface
REQ-001 Parameters: none; widths fixed by shared package (K=12 data, N=17 codeword, R=5 parity).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  codeword and ref_bits are valid this cycle.
REQ-006 codeword  input  17  received Hamming(17,12) word; bit i = code position i+1.
REQ-007 ref_bits  input  12  reference information bits for error counting.
REQ-008 out_valid  output  1  registered result valid.
REQ-009 esti_bits  output  12  corrected, estimated information bits.
REQ-010 syndrome  output  5  computed syndrome; 0 = no error detected.
REQ-011 corrected  output  1  syndrome in 1..17; one bit flipped.
REQ-012 uncorrectable  output  1  syndrome in 18..31; no correction applied.
REQ-013 ham_dis  output  4  count of bit positions where esti_bits differs from ref_bits.

Function
REQ-014 Code SHALL be even-parity Hamming(17,12): parity at positions 1,2,4,8,16; data at 3,5,6,7,9,10,11,12,13,14,15,17.
REQ-015 Data mapping SHALL be d0..d11 = positions 3,5,6,7,9,10,11,12,13,14,15,17 (esti_bits[0] = position 3, esti_bits[11] = position 17).
REQ-016 Syndrome bit j SHALL be XOR of all positions p (1..17) with bit j of p set, including the parity position 2^j.
REQ-017 For syndrome 1..17, the position equal to syndrome SHALL be inverted before data extraction; corrected=1.
REQ-018 For syndrome 0, data SHALL pass unchanged; corrected=0, uncorrectable=0.
REQ-019 For syndrome 18..31, data SHALL pass uncorrected; uncorrectable=1, corrected=0.
REQ-020 Errors of two or more bits are not detected as such; miscorrection is the required behaviour.
REQ-021 ham_dis SHALL equal the popcount of esti_bits XOR ref_bits, range 0..12.
REQ-022 Latency SHALL be exactly 1 cycle: inputs sampled at edge k appear on outputs after edge k; out_valid is in_valid delayed by 1.
REQ-023 Fully pipelined: a new word SHALL be accepted every cycle; no backpressure.
REQ-024 When in_valid=0, data outputs SHALL hold their previous values and out_valid SHALL be 0.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight word; the first valid output after release corresponds to the first in_valid sampled after release.

Structure
REQ-027 Package ham_pkg SHALL hold K, N, R, the data-position table, and the syndrome upper limit 17.
REQ-028 Popcount comparison SHALL be a sub-module bit_com (12-bit a, 12-bit b, 4-bit distance), purely combinational.
REQ-029 Syndrome, correction, and extraction SHALL be combinational logic ahead of one output register stage.

Verification
REQ-030 Clean word 17'b0_0000_1010_0111_0101, ref 12'b0000_1010_1111 -> esti 12'b0000_1010_1111, syndrome 0, corrected 0, ham_dis 0.
REQ-031 Clean word 17'b1_1000_1011_1000_1010, ref 12'b1000_1011_0000 -> esti 12'b1000_1011_0000, syndrome 0; back-to-back with the previous word, one result per cycle.
REQ-032 Word 17'b0_0000_1010_0110_0101 (position 5 flipped), ref 12'b0110_1010_1111 -> syndrome 5, corrected 1, esti 12'b0000_1010_1111, ham_dis 2.
REQ-033 Word 17'b0_1000_1010_0111_0110 (positions 1, 2, 16 flipped) -> syndrome 19, uncorrectable 1, esti 12'b0000_1010_1111.
REQ-034 Exhaustive check: every one of the 17 single-bit flips of 17'b0_0001_0000_1000_1110 -> syndrome = flipped position, esti 12'b0001_0000_0001.
REQ-035 Assert rst_n low between two valid inputs -> outputs 0 asynchronously; no stale out_valid after release.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared widths and code layout for the Hamming(17,12) decoder.
// Code positions are 1-based; bit i of a codeword carries position i+1.
package ham_pkg;

  localparam int K       = 12;
  localparam int N       = 17;
  localparam int R       = 5;
  localparam int SYN_MAX = 17;

  // Code position of each information bit d0..d11.
  localparam int DATA_POS [K] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};

  typedef logic [K-1:0] data_t;
  typedef logic [N-1:0] code_t;
  typedef logic [R-1:0] syn_t;

endpackage

// File: rtl/bit_com.sv
// Combinational Hamming distance between two information words.
module bit_com
  import ham_pkg::*;
(
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [3:0]   distance
);

  logic [K-1:0] diff;

  assign diff = a ^ b;

  // NOTE: every variable written in always_comb gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    distance = '0;
    for (int i = 0; i < K; i++) begin
      distance = distance + {3'b000, diff[i]};
    end
  end

endmodule

// File: rtl/ham_dec.sv
// Hamming(17,12) single-error-correcting decoder with one output register
// stage; also reports the distance of the estimate from a reference word.
module ham_dec
  import ham_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] codeword,
  input  logic [K-1:0] ref_bits,
  output logic         out_valid,
  output logic [K-1:0] esti_bits,
  output logic [R-1:0] syndrome,
  output logic         corrected,
  output logic         uncorrectable,
  output logic [3:0]   ham_dis
);

  syn_t  syn_c;
  code_t fixed_c;
  data_t data_c;
  logic  corr_c;
  logic  unc_c;
  logic [3:0] dis_c;

  // Syndrome is the XOR of the indices of all set positions, so a single
  // flipped bit leaves exactly its own position behind.
  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= N; p++) begin
      if (codeword[p-1]) syn_c = syn_c ^ syn_t'(p);
    end
  end

  // Syndromes above SYN_MAX point past the word and are left uncorrected.
  always_comb begin
    fixed_c = codeword;
    corr_c  = 1'b0;
    unc_c   = 1'b0;
    if (syn_c > syn_t'(SYN_MAX)) begin
      unc_c = 1'b1;
    end else if (syn_c != '0) begin
      corr_c = 1'b1;
      for (int p = 1; p <= N; p++) begin
        if (syn_c == syn_t'(p)) fixed_c[p-1] = ~codeword[p-1];
      end
    end
  end

  always_comb begin
    data_c = '0;
    for (int i = 0; i < K; i++) begin
      data_c[i] = fixed_c[DATA_POS[i]-1];
    end
  end

  bit_com u_bit_com (
    .a        (data_c),
    .b        (ref_bits),
    .distance (dis_c)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      esti_bits     <= '0;
      syndrome      <= '0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      ham_dis       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        esti_bits     <= data_c;
        syndrome      <= syn_c;
        corrected     <= corr_c;
        uncorrectable <= unc_c;
        ham_dis       <= dis_c;
      end
    end
  end

endmodule

// File: tb/tb_ham_dec.sv
// Self-checking bench for ham_dec: directed vectors, exhaustive single-bit
// flips, reset behaviour and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ham_dec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [16:0] codeword;
  logic [11:0] ref_bits;
  logic        out_valid;
  logic [11:0] esti_bits;
  logic [4:0]  syndrome;
  logic        corrected;
  logic        uncorrectable;
  logic [3:0]  ham_dis;

  int n_assert = 0;
  int n_fail   = 0;

  int pos_tab [12] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};

  // Expected registered outputs.
  logic        x_valid;
  logic [11:0] x_esti;
  logic [4:0]  x_syn;
  logic        x_corr;
  logic        x_unc;
  logic [3:0]  x_dis;

  ham_dec dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .codeword      (codeword),
    .ref_bits      (ref_bits),
    .out_valid     (out_valid),
    .esti_bits     (esti_bits),
    .syndrome      (syndrome),
    .corrected     (corrected),
    .uncorrectable (uncorrectable),
    .ham_dis       (ham_dis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decoding rules in plain arithmetic: syndrome = XOR of set position numbers.
  function automatic void model(input logic [16:0] cw, input logic [11:0] rf,
                                output logic [11:0] e, output logic [4:0] s,
                                output logic c, output logic u, output logic [3:0] d);
    int sv;
    logic [16:0] w;
    sv = 0;
    for (int p = 1; p <= 17; p++) if (cw[p-1]) sv = sv ^ p;
    w = cw;
    c = 1'b0;
    u = 1'b0;
    if (sv >= 1 && sv <= 17) begin
      w[sv-1] = ~w[sv-1];
      c = 1'b1;
    end else if (sv > 17) begin
      u = 1'b1;
    end
    for (int i = 0; i < 12; i++) e[i] = w[pos_tab[i]-1];
    s = 5'(sv);
    d = 4'($countones(e ^ rf));
  endfunction

  function automatic logic [16:0] encode(input logic [11:0] data);
    logic [16:0] w;
    int sv;
    w = '0;
    for (int i = 0; i < 12; i++) w[pos_tab[i]-1] = data[i];
    sv = 0;
    for (int p = 1; p <= 17; p++) if (w[p-1]) sv = sv ^ p;
    for (int j = 0; j < 5; j++) if (sv[j]) w[(1 << j) - 1] = 1'b1;
    return w;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(x_valid));
    check({tag, ".esti"},  32'(esti_bits), 32'(x_esti));
    check({tag, ".syn"},   32'(syndrome),  32'(x_syn));
    check({tag, ".corr"},  32'(corrected), 32'(x_corr));
    check({tag, ".unc"},   32'(uncorrectable), 32'(x_unc));
    check({tag, ".dis"},   32'(ham_dis),   32'(x_dis));
  endtask

  // One clock: apply inputs, advance the model, compare 1 ns after the edge.
  task automatic step(input string tag, input logic v, input logic [16:0] cw, input logic [11:0] rf);
    in_valid = v;
    codeword = cw;
    ref_bits = rf;
    @(posedge clk);
    #1;
    x_valid = v;
    if (v) model(cw, rf, x_esti, x_syn, x_corr, x_unc, x_dis);
    check_all(tag);
  endtask

  initial begin
    logic [16:0] base;
    logic [16:0] cw;
    logic [11:0] d;
    logic [11:0] rf;
    int          nflip;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    codeword = '0;
    ref_bits = '0;
    {x_valid, x_esti, x_syn, x_corr, x_unc, x_dis} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back to back.
    step("clean_a", 1'b1, 17'b0_0000_1010_0111_0101, 12'b0000_1010_1111);
    check("clean_a.spec_esti", 32'(esti_bits), 32'h0AF);
    check("clean_a.spec_syn",  32'(syndrome),  32'h0);
    check("clean_a.spec_dis",  32'(ham_dis),   32'h0);
    step("clean_b", 1'b1, 17'b1_1000_1011_1000_1010, 12'b1000_1011_0000);
    check("clean_b.spec_esti", 32'(esti_bits), 32'h8B0);
    check("clean_b.spec_syn",  32'(syndrome),  32'h0);
    step("flip5", 1'b1, 17'b0_0000_1010_0110_0101, 12'b0110_1010_1111);
    check("flip5.spec_syn",  32'(syndrome),  32'd5);
    check("flip5.spec_corr", 32'(corrected), 32'd1);
    check("flip5.spec_esti", 32'(esti_bits), 32'h0AF);
    check("flip5.spec_dis",  32'(ham_dis),   32'd2);
    step("triple", 1'b1, 17'b0_1000_1010_0111_0110, 12'b0000_1010_1111);
    check("triple.spec_syn",  32'(syndrome),      32'd19);
    check("triple.spec_unc",  32'(uncorrectable), 32'd1);
    check("triple.spec_corr", 32'(corrected),     32'd0);
    check("triple.spec_esti", 32'(esti_bits),     32'h0AF);

    // Idle cycle: data holds, out_valid drops.
    step("idle", 1'b0, 17'h1FFFF, 12'hFFF);
    check("idle.hold_syn", 32'(syndrome), 32'd19);

    // Every single-bit flip of one valid word.
    base = 17'b0_0001_0000_1000_1110;
    for (int p = 1; p <= 17; p++) begin
      cw = base;
      cw[p-1] = ~cw[p-1];
      step($sformatf("flip%0d", p), 1'b1, cw, 12'b0001_0000_0001);
      check($sformatf("flip%0d.spec_syn", p),  32'(syndrome),  32'(p));
      check($sformatf("flip%0d.spec_esti", p), 32'(esti_bits), 32'h101);
    end

    // Asynchronous reset between two valid inputs, mid-cycle.
    step("pre_rst", 1'b1, 17'b0_0000_1010_0110_0101, 12'h000);
    rst_n = 1'b0;
    #1;
    {x_valid, x_esti, x_syn, x_corr, x_unc, x_dis} = '0;
    check_all("rst_async");
    in_valid = 1'b1;
    codeword = 17'b0_1000_1010_0111_0110;
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_idle", 1'b0, 17'b0_1000_1010_0111_0110, 12'hFFF);
    step("post_rst_first", 1'b1, 17'b1_1000_1011_1000_1010, 12'h000);

    // Randomized traffic: encoded words with 0..2 flips, or raw words.
    for (int n = 0; n < 400; n++) begin
      d  = 12'($urandom);
      rf = ($urandom_range(0, 1) == 0) ? d : 12'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        cw = 17'($urandom);
      end else begin
        cw = encode(d);
        nflip = $urandom_range(0, 2);
        for (int f = 0; f < nflip; f++) begin
          int bp;
          bp = $urandom_range(0, 16);
          cw[bp] = ~cw[bp];
        end
      end
      step($sformatf("rand%0d", n), ($urandom_range(0, 5) != 0), cw, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
